fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'd8000: redirect target used for exceptions.
REQ-002 Parameter FILL_TIMEOUT, default 64: number of FILL cycles without ic_ready before a fill retry.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 hazard_stall  input  1  decode/execute hazard; PC must hold.
REQ-006 ic_miss  input  1  icache miss on the current PC, valid this cycle.
REQ-007 ic_ready  input  1  icache line fill complete, one-cycle pulse.
REQ-008 br_taken  input  1  taken-branch redirect from EX, one-cycle pulse.
REQ-009 br_target  input  32  branch target, valid with br_taken.
REQ-010 exc_valid  input  1  exception redirect, one-cycle pulse.
REQ-011 stall  output  1  drives the PC incrementer's stall.
REQ-012 PCSrc  output  1  drives the PC incrementer's PCSrc.
REQ-013 PC_branch  output  32  drives the PC incrementer's PC_branch.
REQ-014 ic_fill_req  output  1  level request to the icache; held until ic_ready.
REQ-015 redirect_pending  output  1  a latched redirect awaits issue.
REQ-016 stall_cycles  output  32  stall performance counter (see Configuration).

Function
REQ-017 The FSM SHALL have exactly three states, RUN, FILL and RETRY, stored in registers.
REQ-018 In RUN, a redirect source (exc_valid, else br_taken) SHALL, when hazard_stall=0 and pending is empty, give PCSrc=1, PC_branch=target and stall=0 in the same cycle; ic_miss is ignored that cycle.
REQ-019 Exception SHALL win over branch in the same cycle; its target is EXC_VECTOR.
REQ-020 In RUN with no redirect issuing, stall SHALL equal hazard_stall | ic_miss.
REQ-021 In RUN with ic_miss=1, hazard_stall=0 and no redirect, the next state SHALL be FILL.
REQ-022 In FILL, stall=1 and ic_fill_req=1; ic_ready=1 SHALL move the FSM to RUN, and ic_fill_req SHALL be 0 from the next cycle.
REQ-023 In FILL, a cycle counter SHALL reach FILL_TIMEOUT-1 without ic_ready to enter RETRY; RETRY lasts one cycle with stall=1 and ic_fill_req=0, then returns to FILL with the counter cleared.
REQ-024 A redirect arriving when it cannot issue (FILL, RETRY, hazard_stall=1, or pending occupied) SHALL be latched into the pending register, and redirect_pending SHALL be 1 from the next cycle.
REQ-025 Pending overwrite rules: an exception SHALL replace a pending branch; a branch SHALL NOT replace any pending entry.
REQ-026 A pending redirect SHALL issue (PCSrc=1, PC_branch=pending target, stall=0) in the first RUN cycle with hazard_stall=0, and SHALL clear the pending register on that edge.
REQ-027 An in-progress fill SHALL NOT be aborted by a redirect.
REQ-028 When PCSrc=0, PC_branch SHALL be 32'd0.

Reset
REQ-029 While reset=0 the block SHALL be in state RUN with stall=0, PCSrc=0, PC_branch=0, ic_fill_req=0, redirect_pending=0, the timeout counter=0 and stall_cycles=0.
REQ-030 A reset mid-FILL SHALL drop ic_fill_req asynchronously and discard any pending redirect.

Configuration
REQ-031 With macro FETCH_STALL_CNT_EN defined, stall_cycles SHALL count clk edges with stall=1 and saturate at 32'hFFFFFFFF.
REQ-032 Without FETCH_STALL_CNT_EN, stall_cycles SHALL be constant 0 and no counter register is implemented.

Verification
REQ-033 Bench SHALL drive ic_miss=1 in RUN and ic_ready after 5 FILL cycles -> stall=1 for 6 cycles, ic_fill_req=1 for 5 cycles, then stall=0 in RUN.
REQ-034 Bench SHALL drive br_taken with br_target=32'd1200 during FILL -> redirect_pending=1; after ic_ready, one cycle with PCSrc=1, PC_branch=1200, stall=0.
REQ-035 Bench SHALL drive br_taken=1 and exc_valid=1 in the same RUN cycle -> PCSrc=1, PC_branch=8000.
REQ-036 Bench SHALL hold FILL with ic_ready=0 and FILL_TIMEOUT=4 -> ic_fill_req pattern 1,1,1,1,0,1, ...
REQ-037 Bench SHALL pulse reset=0 mid-FILL with a pending branch -> all outputs 0 immediately; after release, state RUN and redirect_pending=0.
REQ-038 With FETCH_STALL_CNT_EN, after REQ-033 the bench SHALL read stall_cycles=6; without the macro it SHALL read 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch controller: sequences icache miss fills and steers the PC incrementer
// (stall, PCSrc, PC_branch) for branch and exception redirects. Redirects that
// cannot issue immediately are parked in a single-entry pending register.
// Optional feature: define FETCH_STALL_CNT_EN to implement the saturating
// stall_cycles performance counter; otherwise stall_cycles is tied to zero.
//
// state | meaning
// RUN   | normal fetch; redirects issue here, a miss launches a fill
// FILL  | line fill requested, waiting for ic_ready (timeout counter runs)
// RETRY | one-cycle drop of the fill request after a timeout, then re-FILL
module fetch_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'd8000,
    parameter int unsigned FILL_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hazard_stall,
    input  logic        ic_miss,
    input  logic        ic_ready,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_valid,
    output logic        stall,
    output logic        PCSrc,
    output logic [31:0] PC_branch,
    output logic        ic_fill_req,
    output logic        redirect_pending,
    output logic [31:0] stall_cycles
);

    localparam int unsigned CW = (FILL_TIMEOUT > 1) ? $clog2(FILL_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILL_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FILL  = 2'd1,
        RETRY = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_valid_q, pend_valid_d;
    logic          pend_exc_q, pend_exc_d;
    logic [31:0]   pend_tgt_q, pend_tgt_d;

    logic          new_redir;
    logic [31:0]   new_tgt;
    logic          issued_new;

    assign new_redir        = exc_valid | br_taken;
    assign new_tgt          = exc_valid ? EXC_VECTOR : br_target;
    assign redirect_pending = pend_valid_q;

    // State, timeout counter and pending redirect registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_exc_q   <= 1'b0;
            pend_tgt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_exc_q   <= pend_exc_d;
            pend_tgt_q   <= pend_tgt_d;
        end
    end

    // Next-state, pending-register update and PC-incrementer steering.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;
        pend_exc_d   = pend_exc_q;
        pend_tgt_d   = pend_tgt_q;
        stall        = 1'b0;
        PCSrc        = 1'b0;
        PC_branch    = 32'd0;
        ic_fill_req  = 1'b0;
        issued_new   = 1'b0;

        unique case (state_q)
            RUN: begin
                if (!hazard_stall && pend_valid_q) begin
                    // Older parked redirect goes first; the slot frees on this edge.
                    PCSrc        = 1'b1;
                    PC_branch    = pend_tgt_q;
                    pend_valid_d = 1'b0;
                end else if (!hazard_stall && new_redir) begin
                    PCSrc      = 1'b1;
                    PC_branch  = new_tgt;
                    issued_new = 1'b1;
                end else begin
                    stall = hazard_stall | ic_miss;
                    if (ic_miss && !hazard_stall) begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end
                end
            end
            FILL: begin
                stall       = 1'b1;
                ic_fill_req = 1'b1;
                if (ic_ready) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RETRY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RETRY: begin
                stall   = 1'b1;
                state_d = FILL;
                cnt_d   = '0;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        // Park a redirect that could not issue. The slot is free if empty or
        // being drained this cycle; otherwise only an exception may displace
        // a parked branch.
        if (new_redir && !issued_new) begin
            if (!pend_valid_d || (exc_valid && !pend_exc_q)) begin
                pend_valid_d = 1'b1;
                pend_exc_d   = exc_valid;
                pend_tgt_d   = new_tgt;
            end
        end

        // Outputs are forced quiet while reset is asserted, independent of inputs.
        if (!reset) begin
            stall       = 1'b0;
            PCSrc       = 1'b0;
            PC_branch   = 32'd0;
            ic_fill_req = 1'b0;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of clock edges that see stall asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
